// File: rtl/gene_cycle_detector.sv
// Attractor detector: watches a stream of network states and locks onto the
// shortest repeating cycle (period 1..DEPTH), tracking it until the trajectory leaves.
module gene_cycle_detector #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16,
  localparam int PW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             x_valid,
  input  logic [WIDTH-1:0] x,
  output logic             flag,
  output logic [PW-1:0]    period,
  output logic [CNT_W-1:0] transient,
  output logic [CNT_W-1:0] steps,
  output logic             broke
);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    fill;
  logic [WIDTH-1:0] hist [1:DEPTH];

  logic             accept_p0;
  logic             match_any;
  logic [PW-1:0]    match_k;
  logic             lock_eq;

  logic             flag_d;
  logic [PW-1:0]    period_d;
  logic [CNT_W-1:0] transient_d;
  logic             broke_d;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [PW-1:0] sat_inc_fill(input logic [PW-1:0] v);
    return (v == PW'(DEPTH)) ? v : v + PW'(1);
  endfunction

  // A lock taken after the step counter has saturated cannot report a true index.
  function automatic logic [CNT_W-1:0] lock_index(input logic [CNT_W-1:0] idx,
                                                  input logic [PW-1:0]    k);
    return (idx == '1) ? '1 : idx - CNT_W'(k);
  endfunction

  assign accept_p0 = x_valid && !clear;

  // Parallel compare against the pre-shift history; downward scan keeps the lowest k.
  always_comb begin
    match_any = 1'b0;
    match_k   = '0;
    lock_eq   = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (PW'(k) <= fill && x == hist[k]) begin
        match_any = 1'b1;
        match_k   = PW'(k);
      end
    end
    for (int k = 1; k <= DEPTH; k++) begin
      if (PW'(k) == period && x == hist[k]) lock_eq = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    flag_d      = flag;
    period_d    = period;
    transient_d = transient;
    broke_d     = 1'b0;
    if (clear) begin
      state_d     = SEARCH;
      flag_d      = 1'b0;
      period_d    = '0;
      transient_d = '0;
    end else if (x_valid) begin
      case (state_q)
        SEARCH: begin
          if (match_any) begin
            state_d     = LOCKED;
            flag_d      = 1'b1;
            period_d    = match_k;
            transient_d = lock_index(steps, match_k);
          end
        end
        LOCKED: begin
          // A breaking sample never relocks in the same cycle.
          if (!lock_eq) begin
            state_d  = SEARCH;
            flag_d   = 1'b0;
            period_d = '0;
            broke_d  = 1'b1;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  // Stage p0 -> registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SEARCH;
      fill      <= '0;
      steps     <= '0;
      flag      <= 1'b0;
      period    <= '0;
      transient <= '0;
      broke     <= 1'b0;
    end else begin
      state_q   <= state_d;
      flag      <= flag_d;
      period    <= period_d;
      transient <= transient_d;
      broke     <= broke_d;
      if (clear) begin
        fill  <= '0;
        steps <= '0;
      end else if (x_valid) begin
        fill  <= sat_inc_fill(fill);
        steps <= sat_inc_cnt(steps);
      end
    end
  end

  // History contents are gated by fill, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept_p0) begin
      hist[1] <= x;
      for (int k = 2; k <= DEPTH; k++) hist[k] <= hist[k-1];
    end
  end

endmodule

// File: tb/tb_gene_cycle_detector.sv
// Bench for gene_cycle_detector: directed scenarios plus randomized stream
// checked against a queue-based reference model.
module tb_gene_cycle_detector;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int CNT_W = 6;
  localparam int PW    = $clog2(DEPTH + 1);
  localparam int MAXS  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic             flag;
    logic [PW-1:0]    period;
    logic [CNT_W-1:0] transient;
    logic [CNT_W-1:0] steps;
    logic             broke;
  } obs_t;

  logic             clk, rst_n, clear, x_valid;
  logic [WIDTH-1:0] x;
  logic             flag, broke;
  logic [PW-1:0]    period;
  logic [CNT_W-1:0] transient, steps;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [WIDTH-1:0] m_hist[$];
  int m_steps, m_period, m_transient;
  bit m_locked, m_broke;

  gene_cycle_detector #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .x_valid(x_valid), .x(x),
    .flag(flag), .period(period), .transient(transient), .steps(steps), .broke(broke)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t cur();
    return '{flag, period, transient, steps, broke};
  endfunction

  function automatic obs_t mk(int f, int p, int t, int s, int b);
    obs_t o;
    o.flag = f[0]; o.period = PW'(p); o.transient = CNT_W'(t);
    o.steps = CNT_W'(s); o.broke = b[0];
    return o;
  endfunction

  function automatic obs_t model_obs();
    return mk(int'(m_locked), m_period, m_transient, m_steps, int'(m_broke));
  endfunction

  task automatic model_reset();
    m_hist.delete();
    m_steps = 0; m_period = 0; m_transient = 0; m_locked = 0; m_broke = 0;
  endtask

  task automatic model_apply(input bit v, input logic [WIDTH-1:0] d, input bit c);
    m_broke = 0;
    if (c) begin
      model_reset();
      return;
    end
    if (!v) return;
    if (!m_locked) begin
      for (int k = 1; k <= m_hist.size(); k++) begin
        if (m_hist[k-1] == d) begin
          m_locked = 1;
          m_period = k;
          m_transient = (m_steps == MAXS) ? MAXS : m_steps - k;
          break;
        end
      end
    end else if (m_hist[m_period-1] != d) begin
      m_locked = 0;
      m_period = 0;
      m_broke  = 1;
    end
    m_hist.push_front(d);
    if (m_hist.size() > DEPTH) void'(m_hist.pop_back());
    if (m_steps < MAXS) m_steps++;
  endtask

  task automatic step(input bit v, input logic [WIDTH-1:0] d, input bit c);
    @(negedge clk);
    x_valid = v; x = d; clear = c;
    @(posedge clk);
    model_apply(v, d, c);
    #1;
    x_valid = 1'b0; clear = 1'b0;
  endtask

  task automatic test_reset();
    obs_t exp;
    step(1, 8'd5, 0);
    step(1, 8'd5, 0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    exp = mk(0, 0, 0, 0, 0);
    checks++;
    if (cur() !== exp) begin
      errors++; $display("FAIL reset_async: got %p required %p", cur(), exp);
    end
    @(negedge clk) rst_n = 1'b1;
    step(1, 8'd0, 0);
    exp = mk(0, 0, 0, 1, 0);
    checks++;
    if (cur() !== exp) begin
      errors++; $display("FAIL reset_first_zero: got %p required %p", cur(), exp);
    end
  endtask

  task automatic test_fixed_point();
    obs_t exp;
    step(0, 8'd0, 1);
    step(1, 8'd5, 0);
    exp = mk(0, 0, 0, 1, 0);
    checks++;
    if (cur() !== exp) begin
      errors++; $display("FAIL fixed_first: got %p required %p", cur(), exp);
    end
    step(1, 8'd5, 0);
    exp = mk(1, 1, 0, 2, 0);
    checks++;
    if (cur() !== exp) begin
      errors++; $display("FAIL fixed_lock: got %p required %p", cur(), exp);
    end
  endtask

  task automatic test_period3();
    logic [WIDTH-1:0] seq [8] = '{1, 2, 3, 4, 2, 3, 4, 2};
    obs_t exp;
    step(0, 8'd0, 1);
    for (int i = 0; i < 8; i++) begin
      step(1, seq[i], 0);
      if (i == 3) begin
        exp = mk(0, 0, 0, 4, 0);
        checks++;
        if (cur() !== exp) begin
          errors++; $display("FAIL p3_before_lock: got %p required %p", cur(), exp);
        end
      end
      if (i == 4) begin
        exp = mk(1, 3, 1, 5, 0);
        checks++;
        if (cur() !== exp) begin
          errors++; $display("FAIL p3_lock: got %p required %p", cur(), exp);
        end
      end
    end
    exp = mk(1, 3, 1, 8, 0);
    checks++;
    if (cur() !== exp) begin
      errors++; $display("FAIL p3_hold: got %p required %p", cur(), exp);
    end
  endtask

  task automatic test_break();
    obs_t exp;
    step(0, 8'd0, 1);
    step(1, 8'd7, 0); step(1, 8'd9, 0); step(1, 8'd7, 0); step(1, 8'd9, 0);
    exp = mk(1, 2, 0, 4, 0);
    checks++;
    if (cur() !== exp) begin
      errors++; $display("FAIL break_lock2: got %p required %p", cur(), exp);
    end
    step(1, 8'd3, 0);
    exp = mk(0, 0, 0, 5, 1);
    checks++;
    if (cur() !== exp) begin
      errors++; $display("FAIL break_pulse: got %p required %p", cur(), exp);
    end
    step(0, 8'd0, 0);
    exp = mk(0, 0, 0, 5, 0);
    checks++;
    if (cur() !== exp) begin
      errors++; $display("FAIL break_one_cycle: got %p required %p", cur(), exp);
    end
    step(1, 8'd9, 0);
    exp = mk(1, 2, 3, 6, 0);
    checks++;
    if (cur() !== exp) begin
      errors++; $display("FAIL break_relock: got %p required %p", cur(), exp);
    end
    // 9 equals hist[1] but not hist[2]: must break and must not relock
    step(1, 8'd9, 0);
    exp = mk(0, 0, 3, 7, 1);
    checks++;
    if (cur() !== exp) begin
      errors++; $display("FAIL break_no_relock: got %p required %p", cur(), exp);
    end
  endtask

  task automatic test_gaps_and_clear();
    obs_t exp;
    step(0, 8'd0, 1);
    for (int i = 1; i <= 6; i++) begin
      step(1, (i % 2) ? 8'd4 : 8'd6, 0);
      step(0, 8'hAA, 0);
      exp = (i < 3) ? mk(0, 0, 0, i, 0) : mk(1, 2, 0, i, 0);
      checks++;
      if (cur() !== exp) begin
        errors++; $display("FAIL gaps_sample%0d: got %p required %p", i, cur(), exp);
      end
    end
    step(1, 8'd4, 1);
    exp = mk(0, 0, 0, 0, 0);
    checks++;
    if (cur() !== exp) begin
      errors++; $display("FAIL clear_with_valid: got %p required %p", cur(), exp);
    end
    step(1, 8'd4, 0);
    exp = mk(0, 0, 0, 1, 0);
    checks++;
    if (cur() !== exp) begin
      errors++; $display("FAIL clear_history_empty: got %p required %p", cur(), exp);
    end
  endtask

  task automatic test_depth_limit();
    obs_t exp;
    step(0, 8'd0, 1);
    for (int i = 0; i < 30; i++) begin
      step(1, WIDTH'((i % 9) + 1), 0);
      checks++;
      if (flag !== 1'b0) begin
        errors++; $display("FAIL depth_p9_sample%0d: got flag=%b required flag=0", i, flag);
      end
    end
    step(0, 8'd0, 1);
    for (int i = 0; i < 8; i++) step(1, WIDTH'(i + 1), 0);
    exp = mk(0, 0, 0, 8, 0);
    checks++;
    if (cur() !== exp) begin
      errors++; $display("FAIL depth_p8_pre: got %p required %p", cur(), exp);
    end
    step(1, 8'd1, 0);
    exp = mk(1, 8, 0, 9, 0);
    checks++;
    if (cur() !== exp) begin
      errors++; $display("FAIL depth_p8_lock: got %p required %p", cur(), exp);
    end
  endtask

  task automatic test_saturation();
    obs_t exp;
    step(0, 8'd0, 1);
    for (int i = 0; i < MAXS; i++) step(1, WIDTH'(i), 0);
    exp = mk(0, 0, 0, MAXS, 0);
    checks++;
    if (cur() !== exp) begin
      errors++; $display("FAIL sat_steps: got %p required %p", cur(), exp);
    end
    step(1, WIDTH'(MAXS - 1), 0);
    exp = mk(1, 1, MAXS, MAXS, 0);
    checks++;
    if (cur() !== exp) begin
      errors++; $display("FAIL sat_transient: got %p required %p", cur(), exp);
    end
  endtask

  task automatic test_random();
    obs_t exp;
    bit v, c;
    logic [WIDTH-1:0] d;
    step(0, 8'd0, 1);
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 3) != 0);
      d = WIDTH'($urandom_range(0, (i < 300) ? 3 : 6));
      c = ($urandom_range(0, 99) == 0);
      step(v, d, c);
      exp = model_obs();
      checks++;
      if (cur() !== exp) begin
        errors++; $display("FAIL random_%0d: got %p required %p", i, cur(), exp);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; x_valid = 1'b0; x = '0;
    model_reset();
    #12 rst_n = 1'b1;
    test_reset();
    test_fixed_point();
    test_period3();
    test_break();
    test_gaps_and_clear();
    test_depth_limit();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
